// File: rtl/sobel_edge_pkg.sv
// Shared image geometry, output encodings and gradient helpers for the Sobel stage.
// Constants only; no timing and no flow control.
package sobel_edge_pkg;

    localparam int IMG_W = 100;
    localparam int IMG_H = 100;
    localparam int AW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);

    localparam logic [10:0] THR_DEF  = 11'd60;
    localparam logic [7:0]  EDGE_VAL = 8'hFF;
    localparam logic [7:0]  BG_VAL   = 8'h00;

    typedef logic [7:0] pix_t;

    // One window column, listed top to bottom.
    typedef struct packed {
        pix_t top;
        pix_t mid;
        pix_t bot;
    } col_t;

    function automatic logic [10:0] wsum121(pix_t a, pix_t b, pix_t c);
        return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
    endfunction

    function automatic logic [10:0] abs11(logic signed [10:0] x);
        return x[10] ? 11'(-x) : 11'(x);
    endfunction

endpackage

// File: rtl/sobel_edge_if.sv
// Pixel strobe bus: grayscale pixels in, binarised edge pixels out.
// Strobe-only transfers; the bus has no backpressure.
interface sobel_edge_if;
    logic [7:0] pi_data;
    logic       pi_flag;
    logic [7:0] po_data;
    logic       po_flag;

    modport master (output pi_data, pi_flag, input  po_data, po_flag);
    modport slave  (input  pi_data, pi_flag, output po_data, po_flag);
endinterface

// File: rtl/sobel_edge_line_buf.sv
// One image line of pixel storage; read-before-write, read data registered on en_i.
// No backpressure; one access per strobe.
module line_buf
    import sobel_edge_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [AW-1:0] addr_i,
    input  pix_t          wdat_i,
    output pix_t          old_o,
    output pix_t          rd_o
);

    pix_t mem [IMG_W];
    pix_t rd_q;

    // Word at the address before this cycle's write; feeds the next buffer in the cascade.
    assign old_o = mem[addr_i];
    assign rd_o  = rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (en_i) begin
            rd_q <= old_o;
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem[addr_i] <= wdat_i;
        end
    end

endmodule

// File: rtl/sobel_edge.sv
// 3x3 Sobel edge detector on a raster pixel stream; po_flag follows pi_flag by 4 cycles.
// No backpressure: accepts a pixel on any cycle, output rate equals input rate.
module sobel_edge
    import sobel_edge_pkg::*;
#(
    parameter logic [10:0] THR = THR_DEF
)
(
    input logic         sys_clk,
    input logic         sys_rst_n,
    sobel_edge_if.slave pix
);

    logic [AW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    pix_t lb1_old, lb1_rd, lb2_rd, lb2_cas_unused;
    pix_t pix_q;
    col_t win_l_q, win_m_q, win_r;

    logic                v1_q, v2_q, v3_q;
    logic signed [10:0]  gx_q, gy_q, gx_d, gy_d;
    logic        [10:0]  sum_q, sum_d;
    logic                po_flag_q;
    pix_t                po_data_q, po_data_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pix.pi_flag) begin
            if (col_q == AW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    line_buf u_lb1 (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .en_i   (pix.pi_flag),
        .addr_i (col_q),
        .wdat_i (pix.pi_data),
        .old_o  (lb1_old),
        .rd_o   (lb1_rd)
    );

    line_buf u_lb2 (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .en_i   (pix.pi_flag),
        .addr_i (col_q),
        .wdat_i (lb1_old),
        .old_o  (lb2_cas_unused),
        .rd_o   (lb2_rd)
    );

    // The line-buffer read registers plus pix_q are the window's right column.
    assign win_r = {lb2_rd, lb1_rd, pix_q};

    always_comb begin
        gx_d      = signed'(wsum121(win_r.top, win_r.mid, win_r.bot)
                          - wsum121(win_l_q.top, win_l_q.mid, win_l_q.bot));
        gy_d      = signed'(wsum121(win_l_q.bot, win_m_q.bot, win_r.bot)
                          - wsum121(win_l_q.top, win_m_q.top, win_r.top));
        sum_d     = abs11(gx_q) + abs11(gy_q);
        po_data_d = (sum_q >= THR) ? EDGE_VAL : BG_VAL;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            pix_q     <= '0;
            win_l_q   <= '0;
            win_m_q   <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            v3_q      <= 1'b0;
            gx_q      <= '0;
            gy_q      <= '0;
            sum_q     <= '0;
            po_flag_q <= 1'b0;
            po_data_q <= BG_VAL;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            v1_q  <= pix.pi_flag && (row_q >= RW'(2)) && (col_q >= AW'(2));
            if (pix.pi_flag) begin
                win_l_q <= win_m_q;
                win_m_q <= win_r;
                pix_q   <= pix.pi_data;
            end
            v2_q      <= v1_q;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            v3_q      <= v2_q;
            sum_q     <= sum_d;
            po_flag_q <= v3_q;
            if (v3_q) begin
                po_data_q <= po_data_d;
            end
        end
    end

    assign pix.po_data = po_data_q;
    assign pix.po_flag = po_flag_q;

endmodule

// File: tb/tb_sobel_edge.sv
// Directed bench for sobel_edge: uniform, step and threshold images, sparse input, mid-frame reset.
module tb_sobel_edge;
    import sobel_edge_pkg::*;

    localparam int FRAME = IMG_W * IMG_H;
    localparam int NOUT  = (IMG_W - 2) * (IMG_H - 2);

    logic sys_clk = 1'b0;
    logic sys_rst_n;
    always #5 sys_clk = ~sys_clk;

    sobel_edge_if pix ();

    sobel_edge #(.THR(THR_DEF)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pix       (pix)
    );

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int exp_q[$];
    int out_log[$];
    int ref_log[$];
    int out_cnt, edge_cnt, first_out_cyc, px202_cyc, snap_row2, mon_e;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    // 0: flat grey; 1: 0/255 step at col 50; 2: 0 / 15 / 29 steps at cols 30 and 60.
    function automatic int pat_pix(input int pat, input int r, input int c);
        if (pat == 0) return 128;
        if (pat == 1) return (c < 50) ? 0 : 255;
        if (c < 30) return 0;
        return (c < 60) ? 15 : 29;
    endfunction

    // Output produced when pixel (r,c) arrives: Sobel of the 3x3 block with corners (r-2,c-2)..(r,c).
    function automatic int ref_out(input int pat, input int r, input int c);
        int gx, gy;
        gx = (pat_pix(pat, r-2, c) + 2*pat_pix(pat, r-1, c) + pat_pix(pat, r, c))
           - (pat_pix(pat, r-2, c-2) + 2*pat_pix(pat, r-1, c-2) + pat_pix(pat, r, c-2));
        gy = (pat_pix(pat, r, c-2) + 2*pat_pix(pat, r, c-1) + pat_pix(pat, r, c))
           - (pat_pix(pat, r-2, c-2) + 2*pat_pix(pat, r-2, c-1) + pat_pix(pat, r-2, c));
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return (gx + gy >= 60) ? 255 : 0;
    endfunction

    function automatic int log_at(input int i);
        if (i < out_log.size()) return out_log[i];
        return -1;
    endfunction

    always @(negedge sys_clk) begin
        if (pix.po_flag) begin
            if (out_cnt == 0) first_out_cyc = cyc;
            out_cnt++;
            out_log.push_back(int'(pix.po_data));
            if (pix.po_data == EDGE_VAL) edge_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_po_flag", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("po_data", int'(pix.po_data), mon_e % 256);
                chk("po_latency", cyc, mon_e / 256);
            end
        end else if (exp_q.size() > 0 && exp_q[0] / 256 <= cyc) begin
            mon_e = exp_q.pop_front();
            chk("po_flag_missing", 0, 1);
        end
    end

    task automatic new_phase();
        out_cnt = 0;
        edge_cnt = 0;
        first_out_cyc = -1;
        out_log.delete();
    endtask

    // Streams n_px pixels (pattern pat0 for the first frame, pat1 after); rows below slow_rows use one strobe per 8 cycles.
    task automatic send(input int pat0, input int pat1, input int n_px, input int slow_rows);
        int r, c, pat;
        for (int idx = 0; idx < n_px; idx++) begin
            r   = (idx / IMG_W) % IMG_H;
            c   = idx % IMG_W;
            pat = (idx < FRAME) ? pat0 : pat1;
            @(posedge sys_clk);
            #1;
            pix.pi_data = 8'(pat_pix(pat, r, c));
            pix.pi_flag = 1'b1;
            if (r >= 2 && c >= 2) exp_q.push_back((cyc + 4) * 256 + ref_out(pat, r, c));
            if (idx == 202) px202_cyc = cyc;
            if (idx == FRAME + 202) snap_row2 = out_cnt;
            if (r < slow_rows) begin
                repeat (7) begin
                    @(posedge sys_clk);
                    #1;
                    pix.pi_flag = 1'b0;
                end
            end
        end
        @(posedge sys_clk);
        #1;
        pix.pi_flag = 1'b0;
    endtask

    task automatic drain();
        repeat (12) @(posedge sys_clk);
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int diffs, nmin, uni_edges;
        pix.pi_flag = 1'b0;
        pix.pi_data = 8'h00;
        sys_rst_n   = 1'b0;
        new_phase();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("reset_po_flag", int'(pix.po_flag), 0);
        chk("reset_po_data", int'(pix.po_data), 0);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        // Uniform frame immediately followed by a vertical-step frame.
        new_phase();
        send(0, 1, 2 * FRAME, 0);
        drain();
        chk("b2b_total_outputs", out_cnt, 2 * NOUT);
        chk("b2b_outputs_before_frame2_row2", snap_row2, NOUT);
        chk("first_out_latency", first_out_cyc - px202_cyc, 4);
        chk("b2b_edge_count", edge_cnt, 196);
        uni_edges = 0;
        for (int i = 0; i < NOUT && i < out_log.size(); i++)
            if (out_log[i] != 0) uni_edges++;
        chk("uniform_nonzero_outputs", uni_edges, 0);
        chk("step_centre_50_49", log_at(NOUT + 49*98 + 48), 255);
        chk("step_centre_50_50", log_at(NOUT + 49*98 + 49), 255);
        chk("step_centre_50_48", log_at(NOUT + 49*98 + 47), 0);
        chk("step_centre_50_51", log_at(NOUT + 49*98 + 50), 0);
        ref_log.delete();
        for (int i = NOUT; i < out_log.size(); i++) ref_log.push_back(out_log[i]);

        // Same step image, first six rows sent at one strobe per 8 cycles.
        new_phase();
        send(1, 1, FRAME, 6);
        drain();
        chk("sparse_output_count", out_cnt, NOUT);
        chk("sparse_first_latency", first_out_cyc - px202_cyc, 4);
        nmin  = (out_log.size() < ref_log.size()) ? out_log.size() : ref_log.size();
        diffs = (out_log.size() > ref_log.size()) ? out_log.size() - ref_log.size()
                                                  : ref_log.size() - out_log.size();
        for (int i = 0; i < nmin; i++)
            if (out_log[i] != ref_log[i]) diffs++;
        chk("sparse_vs_dense_diffs", diffs, 0);

        // Partial frame, asynchronous reset mid-cycle, then a threshold-boundary frame.
        new_phase();
        send(1, 1, 150, 0);
        chk("partial_rows01_no_output", out_cnt, 0);
        @(posedge sys_clk);
        #3 sys_rst_n = 1'b0;
        exp_q.delete();
        repeat (4) begin
            @(negedge sys_clk);
            chk("midreset_po_flag", int'(pix.po_flag), 0);
        end
        chk("midreset_po_data", int'(pix.po_data), 0);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;

        new_phase();
        send(2, 2, FRAME, 0);
        drain();
        chk("thr_output_count", out_cnt, NOUT);
        chk("thr_edge_count", edge_cnt, 196);
        chk("thr_sum60_centre_10_29", log_at(9*98 + 28), 255);
        chk("thr_sum60_centre_10_30", log_at(9*98 + 29), 255);
        chk("thr_flat_centre_10_28", log_at(9*98 + 27), 0);
        chk("thr_sum56_centre_10_59", log_at(9*98 + 58), 0);
        chk("thr_sum56_centre_10_60", log_at(9*98 + 59), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
